// File: rtl/muldiv_if.sv
// Issue/read handshake and HI/LO result bus between the control unit and the multiply sequencer.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             rd_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, srca, srcb, rd_req,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, is_signed, srca, srcb, rd_req,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add 32x32->64 multiplier owning HI/LO, with mfhi/mflo read stall.
// Optional MULDIV_EARLY_TERM_EN: leave RUN as soon as the multiplier is exhausted.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   res;
  logic                 last_step;
  logic                 busy;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct unsigned magnitude, so no saturation is needed.
  assign mag_a = (bus.is_signed && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
  assign mag_b = (bus.is_signed && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
  assign res   = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    last_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = {{WIDTH{1'b0}}, mag_a};
          q_d     = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = bus.is_signed & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
          state_d = RUN;
        end
      end
      RUN: begin
        if (q_q[0]) acc_d = acc_q + m_q;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
        last_step = (cnt_q == CW'(WIDTH-1)) || (q_d == '0);
`else
        last_step = (cnt_q == CW'(WIDTH-1));
`endif
        if (last_step) state_d = FIX;
      end
      FIX: begin
        hi_d    = res[2*WIDTH-1:WIDTH];
        lo_d    = res[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign bus.busy  = busy;
  assign bus.stall = bus.rd_req & busy;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency/product model checked every cycle plus literal results.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  bit   chk_en = 1'b0;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Model: exact product from plain arithmetic, result appears a fixed number of edges later.
  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int lat_of(input logic [31:0] b, input logic s);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int k;
    m = (s && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k + 1;
`else
    return 33;
`endif
  endfunction

  int          rem = 0;
  logic [63:0] pend = '0;
  logic [31:0] ehi = '0, elo = '0;
  logic        edone = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem <= 0; ehi <= '0; elo <= '0; edone <= 1'b0;
    end else begin
      edone <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          {ehi, elo} <= pend;
          edone      <= 1'b1;
        end
      end else if (bus.start) begin
        pend <= prod(bus.srca, bus.srcb, bus.is_signed);
        rem  <= lat_of(bus.srcb, bus.is_signed);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  64'(bus.busy),  64'(rem > 0));
      chk("cyc_done",  64'(bus.done),  64'(edone));
      chk("cyc_stall", 64'(bus.stall), 64'(bus.rd_req && (rem > 0)));
      chk("cyc_hi",    64'(bus.hi),    64'(ehi));
      chk("cyc_lo",    64'(bus.lo),    64'(elo));
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit rd);
    bus.start = 1'b1; bus.srca = a; bus.srcb = b; bus.is_signed = s;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.srca = '0; bus.srcb = '0; bus.is_signed = 1'b0;
    bus.rd_req = rd;
  endtask

  // Returns edges after E0 until done is seen, and busy samples along the way.
  task automatic wait_done(output int n, output int nbusy);
    n = 0; nbusy = 0;
    if (bus.busy) nbusy++;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
      if (bus.busy) nbusy++;
    end
    if (!bus.done) chk("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] xhi, input logic [31:0] xlo,
                        input int lat_off, input int lat_on, input bit rd);
    int n, nb, xl;
`ifdef MULDIV_EARLY_TERM_EN
    xl = lat_on;
`else
    xl = lat_off;
`endif
    issue(a, b, s, rd);
    wait_done(n, nb);
    chk({nm, "_lat"},  64'(n),      64'(xl));
    chk({nm, "_busy"}, 64'(nb),     64'(xl));
    chk({nm, "_hi"},   64'(bus.hi), 64'(xhi));
    chk({nm, "_lo"},   64'(bus.lo), 64'(xlo));
    if (rd) chk({nm, "_stall_done"}, 64'(bus.stall), 64'(0));
  endtask

  initial begin
    int n, nb, dcnt;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.srca = '0; bus.srcb = '0; bus.rd_req = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("rst_busy",  64'(bus.busy),  64'(0));
    chk("rst_done",  64'(bus.done),  64'(0));
    chk("rst_hi",    64'(bus.hi),    64'(0));
    chk("rst_lo",    64'(bus.lo),    64'(0));
    bus.rd_req = 1'b1;
    #1 chk("rst_stall", 64'(bus.stall), 64'(0));
    bus.rd_req = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_op("u7x6",    32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, 33, 4, 1'b0);
    run_op("s-2x3",   32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 33, 3, 1'b0);
    run_op("s-1x-1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1, 33, 2, 1'b0);
    run_op("umax",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1, 33, 33, 1'b0);
    run_op("smin",    32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 33, 33, 1'b0);

    @(posedge clk); #1;
    run_op("stall",   32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, 33, 4, 1'b1);
    @(posedge clk); #1;
    chk("idle_stall", 64'(bus.stall), 64'(0));
    bus.rd_req = 1'b0;

`ifndef MULDIV_EARLY_TERM_EN
    issue(32'd7, 32'd6, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.srca = 32'd5; bus.srcb = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.srca = '0; bus.srcb = '0;
    wait_done(n, nb);
    chk("ign_lat", 64'(n + 10), 64'(33));
    chk("ign_lo",  64'(bus.lo), 64'(42));
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    chk("ign_nodone", 64'(dcnt), 64'(0));
    chk("ign_idle",   64'(bus.busy), 64'(0));

    issue(32'd7, 32'd6, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'(0));
    chk("mrst_hi",   64'(bus.hi),   64'(0));
    chk("mrst_lo",   64'(bus.lo),   64'(0));
    @(posedge clk); #1 reset = 1'b1;
`endif
    run_op("u3x4",    32'd3, 32'd4, 1'b0, 32'h0, 32'd12, 33, 4, 1'b0);
    run_op("u3x5",    32'd3, 32'd5, 1'b0, 32'h0, 32'd15, 33, 4, 1'b0);
    run_op("u9x0",    32'd9, 32'd0, 1'b0, 32'h0, 32'h0, 33, 2, 1'b0);

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the HI/LO multiply path. It owns the HI and LO registers and computes a 32x32→64 product iteratively, signed or unsigned. It stalls `mfhi`/`mflo` reads until a pending product has retired. It sits beside the ALU in the datapath: the control unit issues `start` on `mult`/`multu` and raises `rd_req` on `mfhi`/`mflo`; the PC/register-write enables are gated by `stall`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; low clears all state immediately.
- `start` in 1: issue a multiply, sampled on rising edge.
- `is_signed` in 1: 1 = `mult` (two's complement), 0 = `multu`; sampled with `start`.
- `srca`, `srcb` in WIDTH: operands (rs, rt); sampled with `start`.
- `rd_req` in 1: an `mfhi`/`mflo` is in decode this cycle.
- `busy` out 1: a product is in flight.
- `stall` out 1: combinational, `rd_req & busy`.
- `done` out 1: one-cycle pulse, HI/LO just updated.
- `hi`, `lo` out WIDTH: product upper and lower halves.

## Operation
- State machine has three states: IDLE, RUN and FIX.
- IDLE:
  - `start`=1 latches operands and the sign flag.
  - Stores |srca| into multiplicand register M (2·WIDTH bits, zero-extended) and |srcb| into multiplier register Q (WIDTH bits).
  - Clears accumulator ACC (2·WIDTH), sets step counter to 0 and goes to RUN.
  - When `is_signed`=0, magnitudes are the raw operands.
  - Negate flag = `is_signed & (srca[MSB] ^ srcb[MSB])`.
- RUN, one step per cycle:
  - If Q[0], ACC += M (mod 2^(2·WIDTH)).
  - M <<= 1, Q >>= 1, counter += 1.
  - After the step with counter = WIDTH-1, go to FIX.
- FIX:
  - hi:lo ← negate ? −ACC : ACC (two's complement, 2·WIDTH bits); `done`=1 next cycle.
  - Returns to IDLE.
- Result is the exact 2·WIDTH-bit product.
  - Operand 0x80000000 signed: its magnitude 2^31 fits unsigned in WIDTH bits; it must not saturate.
- `busy`=1 in RUN and FIX, 0 in IDLE.
- `start` while `busy`: ignored; operands are not captured and the in-flight product is unaffected. The control unit prevents this by stalling on `busy` if required.
- `start` in the same cycle that FIX retires: ignored; the state is still FIX when it is sampled.
- `rd_req` while busy raises `stall`. The first cycle with `busy`=0 (same cycle `done`=1) gives `stall`=0, and `hi`/`lo` already hold the new product.
- HI/LO hold their value until the next FIX; no other write path.

## Timing
- Reset values (reset low, asynchronous): state IDLE; `busy`=0, `done`=0, `stall`=0, `hi`=0, `lo`=0; ACC, M, Q and counter are 0.
- Reset mid-operation aborts the product; HI/LO return to 0. The first rising edge with `reset` high and `start`=1 begins a new product normally.
- Edge E0 samples `start`. RUN covers E1..E32 (WIDTH steps), and the FIX edge is E33.
  - `busy` is high in the cycles after E0 through the cycle before E33.
  - `hi`/`lo` are valid and `done`=1 in the cycle after E33.
  - Latency is WIDTH+1 edges: 33 for the default.
- Back-to-back: `start` may be accepted in the cycle `done`=1, giving a throughput of 1 product per WIDTH+2 cycles.

## Configuration
- `MULDIV_EARLY_TERM_EN` defined:
  - In RUN, after a step leaves Q == 0, go directly to FIX.
  - With Q == 0 at start (multiplier magnitude 0), exactly one RUN step is taken.
  - Latency becomes k+1 edges, where k = max(1, bit index of the highest set bit of |srcb| + 1).
- Not defined: always exactly WIDTH RUN steps, fixed latency WIDTH+1. Results are identical either way.

## Test plan
- Unsigned product: `multu` 7×6 → `done` pulse after E33, hi=0x00000000, lo=0x0000002A; `busy` high for exactly 33 cycles (macro off).
- Signed and extreme-operand results:
  - `mult` −2×3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - `mult` −1×−1 → hi=0, lo=1.
  - `multu` 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
  - `mult` 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- Read stall: hold `rd_req`=1 from the cycle after `start`; `stall`=1 until the cycle `done`=1, where `stall`=0 and lo holds the new value. With `rd_req`=1 in IDLE, `stall`=0.
- Ignored start: `start` with 5×5 at cycle 10 of a busy 7×6 → result still 42, no second `done`, `busy` drops after E33.
- Mid-run reset: pull `reset` low at cycle 15 of a 7×6 → `busy`, `hi`, `lo` read 0 immediately. After release, a 3×4 `start` yields lo=12 with full latency.
- Early termination: with `MULDIV_EARLY_TERM_EN`, `multu` 3×5 → `done` after 4 edges (3 RUN + FIX), lo=15; `multu` 9×0 → `done` after 2 edges, hi=lo=0.
